// File: rtl/merge_rr_arbiter_pkg.sv
// merge_rr_arbiter_pkg: index-width helpers shared by index-producing merge blocks
package merge_rr_arbiter_pkg;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
  function automatic int idx_w(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction
endpackage

// File: rtl/merge_rr_arbiter_rr_priority_pick.sv
// rr_priority_pick: round-robin grant via double-width masked priority scan
module rr_priority_pick #(
  parameter int N = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] sel,
  output logic          any_valid
);
  logic [N-1:0] mask;
  logic [2*N-1:0] dbl;
  // keep only requests at or above ptr in the low half; full request set in the high half handles wrap
  always_comb begin
    mask = '0;
    for (int i = 0; i < N; i++) mask[i] = (i >= int'(ptr));
  end
  assign dbl = {req, req & mask};
  assign any_valid = |req;
  // lowest set bit of the double vector, folded back modulo N
  always_comb begin
    sel = '0;
    for (int i = 2*N-1; i >= 0; i--) if (dbl[i]) sel = PW'(i % N);
    grant = any_valid ? (N'(1) << sel) : '0;
  end
endmodule

// File: rtl/merge_rr_arbiter.sv
// merge_rr_arbiter: fair round-robin N-to-1 merge with a one-slot registered output
module merge_rr_arbiter
  import merge_rr_arbiter_pkg::*;
#(
  parameter int INPUTS = 2,
  parameter int DATA_TYPE = 32,
  parameter int INDEX_TYPE = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [INPUTS*DATA_TYPE-1:0] ins,
  input  logic [INPUTS-1:0]           ins_valid,
  output logic [INPUTS-1:0]           ins_ready,
  output logic [DATA_TYPE-1:0]        outs,
  output logic [INDEX_TYPE-1:0]       index,
  output logic                        outs_valid,
  input  logic                        outs_ready
);
  localparam int PW = idx_w(INPUTS);
  logic full;
  logic [PW-1:0] ptr;
  logic [PW-1:0] sel;
  logic [DATA_TYPE-1:0] data_q;
  logic [INDEX_TYPE-1:0] idx_q;
  logic [INPUTS-1:0] grant;
  logic any_valid;
  logic accept;
  logic xfer;
  rr_priority_pick #(.N(INPUTS), .PW(PW)) pick (
    .req(ins_valid),
    .ptr(ptr),
    .grant(grant),
    .sel(sel),
    .any_valid(any_valid)
  );
  assign accept = !full | outs_ready;
  assign xfer = accept & any_valid;
  assign ins_ready = accept ? grant : '0;
  assign outs = data_q;
  assign index = idx_q;
  assign outs_valid = full;
  // load the winner on transfer, drain when the consumer takes the slot with nothing to refill
  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 1'b0;
      ptr <= '0;
      data_q <= '0;
      idx_q <= '0;
    end else if (xfer) begin
      full <= 1'b1;
      data_q <= ins[int'(sel)*DATA_TYPE +: DATA_TYPE];
      idx_q <= INDEX_TYPE'(sel);
      ptr <= (sel == PW'(INPUTS-1)) ? '0 : sel + 1'b1;
    end else if (outs_ready) begin
      full <= 1'b0;
    end
  end
endmodule

// File: tb/tb_merge_rr_arbiter.sv
// tb_merge_rr_arbiter: directed checks of the round-robin merge at INPUTS=3, 5 and 1
module tb_merge_rr_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [23:0] ins3;
  logic [2:0] v3, r3;
  logic [7:0] o3;
  logic [1:0] i3;
  logic ov3, or3;

  logic [39:0] ins5;
  logic [4:0] v5, r5;
  logic [7:0] o5;
  logic [2:0] i5;
  logic ov5, or5;

  logic [7:0] ins1;
  logic v1, r1;
  logic [7:0] o1;
  logic i1;
  logic ov1, or1;

  merge_rr_arbiter #(.INPUTS(3), .DATA_TYPE(8), .INDEX_TYPE(2)) d3 (
    .clk(clk), .rst(rst), .ins(ins3), .ins_valid(v3), .ins_ready(r3),
    .outs(o3), .index(i3), .outs_valid(ov3), .outs_ready(or3));
  merge_rr_arbiter #(.INPUTS(5), .DATA_TYPE(8), .INDEX_TYPE(3)) d5 (
    .clk(clk), .rst(rst), .ins(ins5), .ins_valid(v5), .ins_ready(r5),
    .outs(o5), .index(i5), .outs_valid(ov5), .outs_ready(or5));
  merge_rr_arbiter #(.INPUTS(1), .DATA_TYPE(8), .INDEX_TYPE(1)) d1 (
    .clk(clk), .rst(rst), .ins(ins1), .ins_valid(v1), .ins_ready(r1),
    .outs(o1), .index(i1), .outs_valid(ov1), .outs_ready(or1));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic out3(input string tag, input logic [7:0] d, input logic [1:0] ix, input logic v);
    chk({tag, "_outs"}, 32'(o3), 32'(d));
    chk({tag, "_index"}, 32'(i3), 32'(ix));
    chk({tag, "_valid"}, 32'(ov3), 32'(v));
  endtask

  task automatic out5(input string tag, input logic [7:0] d, input logic [2:0] ix);
    chk({tag, "_outs"}, 32'(o5), 32'(d));
    chk({tag, "_index"}, 32'(i5), 32'(ix));
    chk({tag, "_valid"}, 32'(ov5), 32'd1);
  endtask

  task automatic out1(input string tag, input logic [7:0] d, input logic v);
    chk({tag, "_outs"}, 32'(o1), 32'(d));
    chk({tag, "_index"}, 32'(i1), 32'd0);
    chk({tag, "_valid"}, 32'(ov1), 32'(v));
  endtask

  initial begin
    rst = 1'b1;
    ins3 = '0; v3 = '0; or3 = 1'b0;
    ins5 = '0; v5 = '0; or5 = 1'b0;
    ins1 = '0; v1 = 1'b0; or1 = 1'b0;
    tick(); tick();
    rst = 1'b0;
    for (int c = 0; c < 5; c++) tick();
    chk("idle_ready", 32'(r3), 32'b000);
    out3("idle", 8'h00, 2'd0, 1'b0);

    ins3 = {8'h0C, 8'h0B, 8'h0A}; v3 = 3'b111; or3 = 1'b1;
    #1 chk("rr_pre_ready", 32'(r3), 32'b001);
    tick(); out3("rr0", 8'h0A, 2'd0, 1'b1); chk("rr0_ready", 32'(r3), 32'b010);
    tick(); out3("rr1", 8'h0B, 2'd1, 1'b1); chk("rr1_ready", 32'(r3), 32'b100);
    tick(); out3("rr2", 8'h0C, 2'd2, 1'b1); chk("rr2_ready", 32'(r3), 32'b001);
    tick(); out3("rr3", 8'h0A, 2'd0, 1'b1);

    ins3 = {8'h22, 8'h11, 8'h05}; v3 = 3'b010;
    tick(); out3("load11", 8'h11, 2'd1, 1'b1);
    v3 = 3'b101; or3 = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1 chk("stall_ready", 32'(r3), 32'b000);
      tick(); out3("stall", 8'h11, 2'd1, 1'b1);
    end
    v3 = 3'b100; or3 = 1'b1;
    #1 chk("refill_ready", 32'(r3), 32'b100);
    tick(); out3("refill", 8'h22, 2'd2, 1'b1);
    v3 = 3'b000;
    #1 chk("drain_ready", 32'(r3), 32'b000);
    tick(); out3("drain", 8'h22, 2'd2, 1'b0);

    ins3 = {8'h00, 8'h55, 8'h00}; v3 = 3'b010;
    tick(); out3("load55", 8'h55, 2'd1, 1'b1);
    v3 = 3'b000; or3 = 1'b0; rst = 1'b1;
    tick(); out3("midrst", 8'h00, 2'd0, 1'b0);
    rst = 1'b0; ins3 = {8'h0C, 8'h0B, 8'h0A}; v3 = 3'b111; or3 = 1'b1;
    #1 chk("postrst_ready", 32'(r3), 32'b001);
    tick(); out3("postrst", 8'h0A, 2'd0, 1'b1);
    v3 = 3'b000;

    ins5 = {8'h44, 8'h33, 8'h00, 8'h41, 8'h00}; v5 = 5'b01000; or5 = 1'b1;
    #1 chk("w5_pre_ready", 32'(r5), 32'b01000);
    tick(); out5("w5_g3", 8'h33, 3'd3);
    v5 = 5'b10010;
    #1 chk("w5_wrap_ready", 32'(r5), 32'b10000);
    tick(); out5("w5_g4", 8'h44, 3'd4);
    chk("w5_skip_ready", 32'(r5), 32'b00010);
    tick(); out5("w5_g1", 8'h41, 3'd1);
    ins5 = {8'h00, 8'h00, 8'h62, 8'h61, 8'h60}; v5 = 5'b00111;
    #1 chk("w5_ptr2_ready", 32'(r5), 32'b00100);
    tick(); out5("w5_g2", 8'h62, 3'd2);
    v5 = 5'b00000;

    ins1 = 8'h01; v1 = 1'b1; or1 = 1'b1;
    #1 chk("s1_ready_a", 32'(r1), 32'd1);
    tick(); out1("s1_a", 8'h01, 1'b1);
    ins1 = 8'h02; or1 = 1'b0;
    #1 chk("s1_ready_b", 32'(r1), 32'd0);
    tick(); out1("s1_b", 8'h01, 1'b1);
    or1 = 1'b1;
    #1 chk("s1_ready_c", 32'(r1), 32'd1);
    tick(); out1("s1_c", 8'h02, 1'b1);
    ins1 = 8'h03; or1 = 1'b0;
    #1 chk("s1_ready_d", 32'(r1), 32'd0);
    tick(); out1("s1_d", 8'h02, 1'b1);
    or1 = 1'b1;
    tick(); out1("s1_e", 8'h03, 1'b1);
    v1 = 1'b0;
    tick(); out1("s1_f", 8'h03, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
